// File: rtl/wrf_rx_sink.sv
// WRF sink: accepts framed 16-bit words, tags each with eof/error and buffers
// them in a first-word fall-through FIFO alongside good/bad frame counters.
module wrf_rx_sink #(
  parameter int g_FIFO_DEPTH     = 64,
  parameter int g_DREQ_THRESHOLD = 8,
  parameter int g_MAX_WORDS      = 760
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] snk_data_i,
  input  logic [3:0]  snk_ctrl_i,
  input  logic        snk_bytesel_i,
  input  logic        snk_sof_p1_i,
  input  logic        snk_eof_p1_i,
  input  logic        snk_valid_i,
  input  logic        snk_rerror_p1_i,
  input  logic        snk_tabort_p1_i,
  output logic        snk_dreq_o,
  output logic        snk_rabort_p1_o,
  output logic        snk_terror_p1_o,
  output logic [15:0] out_data_o,
  output logic [3:0]  out_ctrl_o,
  output logic        out_bytesel_o,
  output logic        out_eof_o,
  output logic        out_error_o,
  output logic        out_valid_o,
  input  logic        out_rd_i,
  output logic [15:0] frames_ok_o,
  output logic [15:0] frames_err_o
);

  // state | meaning
  // IDLE  | waiting for start of frame
  // RECV  | storing words of the current frame
  // DROP  | frame aborted, discarding until next sof
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  localparam int AW  = $clog2(g_FIFO_DEPTH);
  localparam int WCW = $clog2(g_MAX_WORDS + 1);
  localparam logic [AW:0]    DEPTH      = (AW+1)'(g_FIFO_DEPTH);
  localparam logic [AW:0]    DATA_LIMIT = (AW+1)'(g_FIFO_DEPTH - 1);
  localparam logic [AW:0]    DREQ_THR   = (AW+1)'(g_DREQ_THRESHOLD);
  localparam logic [WCW-1:0] MAX_W      = WCW'(g_MAX_WORDS);
  localparam logic [22:0]    MARK_OK    = 23'h000002;
  localparam logic [22:0]    MARK_ERR   = 23'h000003;

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [15:0]    ok_q, ok_d, err_q, err_d;
  logic           dreq_q, dreq_d, rabort_q, rabort_d;
  logic           wr_req, wr_en, rd_en;
  logic [22:0]    wr_entry, rd_entry;
  logic [22:0]    mem_q [g_FIFO_DEPTH];

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    ok_d     = ok_q;
    err_d    = err_q;
    rabort_d = 1'b0;
    wr_req   = 1'b0;
    wr_entry = '0;
    case (state_q)
      S_IDLE: begin
        if (snk_sof_p1_i) begin
          state_d = S_RECV;
          wcnt_d  = '0;
        end
      end
      S_RECV: begin
        if (snk_sof_p1_i) begin
          // previous frame never terminated: close it as bad, start the new one
          wr_req   = 1'b1;
          wr_entry = MARK_ERR;
          err_d    = err_q + 16'd1;
          wcnt_d   = '0;
        end else if (snk_rerror_p1_i || snk_tabort_p1_i) begin
          wr_req   = 1'b1;
          wr_entry = MARK_ERR;
          err_d    = err_q + 16'd1;
          state_d  = S_IDLE;
        end else if (snk_valid_i) begin
          // the last FIFO slot stays free so a terminator can always be stored
          if (count_q >= DATA_LIMIT || wcnt_q == MAX_W) begin
            rabort_d = 1'b1;
            wr_req   = 1'b1;
            wr_entry = MARK_ERR;
            err_d    = err_q + 16'd1;
            state_d  = S_DROP;
          end else begin
            wr_req   = 1'b1;
            wr_entry = {snk_data_i, snk_ctrl_i, snk_bytesel_i, snk_eof_p1_i, 1'b0};
            if (snk_eof_p1_i) begin
              ok_d    = ok_q + 16'd1;
              state_d = S_IDLE;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end else if (snk_eof_p1_i) begin
          wr_req   = 1'b1;
          wr_entry = MARK_OK;
          ok_d     = ok_q + 16'd1;
          state_d  = S_IDLE;
        end
      end
      S_DROP: begin
        if (snk_sof_p1_i) begin
          state_d = S_RECV;
          wcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_en    = out_rd_i && (count_q != '0);
    wr_en    = wr_req && (count_q != DEPTH);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    dreq_d   = (DEPTH - count_q) >= DREQ_THR;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ok_q     <= '0;
      err_q    <= '0;
      dreq_q   <= 1'b1;
      rabort_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      dreq_q   <= dreq_d;
      rabort_q <= rabort_d;
    end
  end

  // storage has no reset; validity is tracked by count_q alone
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_entry        = mem_q[rd_ptr_q];
  assign out_data_o      = rd_entry[22:7];
  assign out_ctrl_o      = rd_entry[6:3];
  assign out_bytesel_o   = rd_entry[2];
  assign out_eof_o       = rd_entry[1];
  assign out_error_o     = rd_entry[0];
  assign out_valid_o     = (count_q != '0);
  assign snk_dreq_o      = dreq_q;
  assign snk_rabort_p1_o = rabort_q;
  assign snk_terror_p1_o = 1'b0;
  assign frames_ok_o     = ok_q;
  assign frames_err_o    = err_q;

endmodule
